// File: rtl/mult_tester_pkg.sv
// Shared types and helpers for the multiplier tester: checker state encoding,
// MISR constants and the width-generic 32-bit XOR fold.
package mult_tester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
  localparam logic [31:0] MISR_SEED = 32'hFFFFFFFF;

  // Widest vector fold32 accepts; callers zero-extend, and the padding chunks fold to zero.
  localparam int FOLD_MAX_W = 512;

  function automatic logic [31:0] fold32(input logic [FOLD_MAX_W-1:0] data);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < FOLD_MAX_W / 32; i++) begin
      acc ^= data[i*32 +: 32];
    end
    return acc;
  endfunction

endpackage

// File: rtl/prod_result_checker_misr32.sv
// 32-bit MISR: folds a WIDTH-bit word to 32 bits and steps a Galois-style
// signature register when enabled; load restores the seed.
module misr32
  import mult_tester_pkg::*;
#(
  parameter int          WIDTH = 127,
  parameter logic [31:0] POLY  = MISR_POLY,
  parameter logic [31:0] SEED  = MISR_SEED
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] data_in,
  output logic [31:0]      sig
);

  logic [FOLD_MAX_W-1:0] data_ext;
  logic [31:0]           fold;
  logic [31:0]           sig_next;

  assign data_ext = FOLD_MAX_W'(data_in);
  assign fold     = fold32(data_ext);
  assign sig_next = {sig[30:0], 1'b0} ^ (sig[31] ? POLY : 32'h0) ^ fold;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/prod_result_checker.sv
// Product stream checker: compares products to expected values over a run of
// num_samples, counting mismatches, capturing the first one and signing all products.
module prod_result_checker
  import mult_tester_pkg::*;
#(
  parameter int          WIDTH      = 127,
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] POLY       = MISR_POLY,
  parameter logic [31:0] SEED       = MISR_SEED
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] num_samples,
  input  logic                  valid_in,
  input  logic [WIDTH-1:0]      prod_in,
  input  logic [WIDTH-1:0]      exp_in,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   sample_count,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic                  first_err_valid,
  output logic [ADDR_WIDTH-1:0] first_err_idx,
  output logic [31:0]           signature
);

  localparam logic [ADDR_WIDTH:0] FULL_DEPTH = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

  state_t              state_q, state_d;
  logic [ADDR_WIDTH:0] target_q;
  logic [ADDR_WIDTH:0] count_inc;
  logic                start_run;
  logic                accept;
  logic                mismatch;
  logic                last_sample;

  assign start_run   = start && (state_q != ST_RUN);
  assign accept      = valid_in && (state_q == ST_RUN);
  assign mismatch    = prod_in != exp_in;
  assign count_inc   = sample_count + 1'b1;
  assign last_sample = accept && (count_inc == target_q);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start)       state_d = ST_RUN;
      ST_RUN:           if (last_sample) state_d = ST_DONE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q         <= ST_IDLE;
      target_q        <= '0;
      sample_count    <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
    end else begin
      state_q <= state_d;
      if (start_run) begin
        target_q        <= (num_samples == '0) ? FULL_DEPTH : {1'b0, num_samples};
        sample_count    <= '0;
        err_count       <= '0;
        first_err_valid <= 1'b0;
        first_err_idx   <= '0;
      end else if (accept) begin
        sample_count <= count_inc;
        if (mismatch) begin
          if (err_count != '1) err_count <= err_count + 1'b1;
          if (!first_err_valid) begin
            // Index is the pre-increment count, i.e. the 0-based position of this sample.
            first_err_valid <= 1'b1;
            first_err_idx   <= sample_count[ADDR_WIDTH-1:0];
          end
        end
      end
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

  misr32 #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clock   (clock),
    .resetn  (resetn),
    .load    (start_run),
    .en      (accept),
    .data_in (prod_in),
    .sig     (signature)
  );

endmodule
